// File: rtl/alu_op_scheduler.sv
// ALU operation scheduler: sequences ADD/MULT/DIV/MOD onto external cores.
// Optional ALU_OP_COUNTERS_EN adds a 32-bit completed-operation counter.
module alu_op_scheduler #(
  parameter int DATA_WIDTH  = 64,
  parameter int OPP_WIDTH   = 2,
  parameter int ADD_LAT     = 1,
  parameter int MULT_LAT    = 2,
  parameter int DIV_TIMEOUT = 255
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [2*DATA_WIDTH-1:0]           s_axis_op_tdata,
  input  logic [OPP_WIDTH-1:0]              s_axis_op_tuser,
  input  logic                              s_axis_op_tvalid,
  output logic                              s_axis_op_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_res_tdata,
  output logic [2:0]                        m_axis_res_tuser,
  output logic                              m_axis_res_tvalid,
  input  logic                              m_axis_res_tready,
  output logic [DATA_WIDTH-1:0]             add_a,
  output logic [DATA_WIDTH-1:0]             add_b,
  input  logic [DATA_WIDTH-1:0]             add_sum,
  output logic [DATA_WIDTH-1:0]             mult_a,
  output logic [DATA_WIDTH-1:0]             mult_b,
  input  logic [DATA_WIDTH-1:0]             mult_result,
  output logic [DATA_WIDTH-1:0]             dividend_tdata,
  output logic                              dividend_tvalid,
  input  logic                              dividend_tready,
  output logic [DATA_WIDTH/2-1:0]           divisor_tdata,
  output logic                              divisor_tvalid,
  input  logic                              divisor_tready,
  input  logic                              div_result_tvalid,
  input  logic [DATA_WIDTH+DATA_WIDTH/2-1:0] div_result_tdata,
  input  logic                              zero_error,
  output logic [31:0]                       ops_done
);

  localparam int HW = DATA_WIDTH / 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OPP_WIDTH-1:0]  op_q, op_d;
  logic [31:0]           tmr_q, tmr_d;
  logic                  dvd_q, dvd_d, dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [2:0]            sts_q, sts_d;

  logic is_add, is_mul, is_div, is_ill, b_zero;
  logic in_div, in_bz, s_hs, both_ok;
  logic [DATA_WIDTH-1:0] quot, rem;

  assign is_add  = op_q == OPP_WIDTH'(0);
  assign is_mul  = op_q == OPP_WIDTH'(1);
  assign is_div  = op_q == OPP_WIDTH'(2);
  assign is_ill  = op_q > OPP_WIDTH'(3);
  assign b_zero  = b_q[HW-1:0] == '0;
  assign in_div  = (s_axis_op_tuser == OPP_WIDTH'(2))
                 | (s_axis_op_tuser == OPP_WIDTH'(3));
  assign in_bz   = s_axis_op_tdata[DATA_WIDTH +: HW] == '0;
  assign s_hs    = s_axis_op_tvalid & s_axis_op_tready;
  assign both_ok = (~dvd_q | dividend_tready)
                 & (~dvs_q | divisor_tready);
  assign quot    = div_result_tdata[DATA_WIDTH+HW-1:HW];
  assign rem     = {{HW{1'b0}}, div_result_tdata[HW-1:0]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tmr_d   = tmr_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    sts_d   = sts_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (s_hs) begin
          a_d     = s_axis_op_tdata[DATA_WIDTH-1:0];
          b_d     = s_axis_op_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
          op_d    = s_axis_op_tuser;
          dvd_d   = in_div & ~in_bz;
          dvs_d   = in_div & ~in_bz;
          state_d = S_ISSUE;
        end
      end
      state_q == S_ISSUE: begin
        if (is_ill) begin
          res_d   = '0;
          sts_d   = 3'b100;
          state_d = S_OUT;
        end else if (is_add | is_mul) begin
          tmr_d   = is_add ? 32'(ADD_LAT) : 32'(MULT_LAT);
          state_d = S_WAIT;
        end else if (b_zero) begin
          res_d   = '0;
          sts_d   = 3'b001;
          state_d = S_OUT;
        end else begin
          // each divider channel retires on its own ready
          dvd_d = dvd_q & ~dividend_tready;
          dvs_d = dvs_q & ~divisor_tready;
          if (both_ok) begin
            tmr_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      state_q == S_WAIT: begin
        if (is_add | is_mul) begin
          if (tmr_q == 32'd1) begin
            res_d   = is_add ? add_sum : mult_result;
            sts_d   = 3'b000;
            state_d = S_OUT;
          end else begin
            tmr_d = tmr_q - 32'd1;
          end
        end else if (div_result_tvalid) begin
          res_d   = zero_error ? '0 : (is_div ? quot : rem);
          sts_d   = {2'b00, zero_error};
          state_d = S_OUT;
        end else if (tmr_q == 32'(DIV_TIMEOUT - 1)) begin
          res_d   = '0;
          sts_d   = 3'b010;
          state_d = S_OUT;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      state_q == S_OUT: begin
        if (m_axis_res_tready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tmr_q   <= '0;
      dvd_q   <= 1'b0;
      dvs_q   <= 1'b0;
      res_q   <= '0;
      sts_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tmr_q   <= tmr_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      sts_q   <= sts_d;
    end
  end

  assign s_axis_op_tready  = (state_q == S_IDLE) & aresetn;
  assign m_axis_res_tvalid = state_q == S_OUT;
  assign m_axis_res_tdata  = res_q;
  assign m_axis_res_tuser  = sts_q;
  assign add_a             = a_q;
  assign add_b             = b_q;
  assign mult_a            = a_q;
  assign mult_b            = b_q;
  assign dividend_tdata    = a_q;
  assign dividend_tvalid   = dvd_q;
  assign divisor_tdata     = b_q[HW-1:0];
  assign divisor_tvalid    = dvs_q;

`ifdef ALU_OP_COUNTERS_EN
  logic [31:0] ops_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ops_q <= '0;
    end else if (m_axis_res_tvalid & m_axis_res_tready) begin
      ops_q <= ops_q + 32'd1;
    end
  end

  assign ops_done = ops_q;
`else
  assign ops_done = '0;
`endif

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
Parametrised successor to the team's single-shot ALU controller. Accepts one operation per transaction on a fully handshaked AXI-Stream input and sequences it onto external adder, multiplier and divider cores. Returns the result with status on a back-pressurable AXI-Stream output. Sits between the command front-end and the arithmetic IP cores, and adds quotient/remainder modes, configurable latencies, divider timeout and error reporting.

Parameters:
DATA_WIDTH, 64, operand/result width (even, >=8)
OPP_WIDTH, 2, opcode width (>=2); codes >=4 are illegal
ADD_LAT, 1, adder core latency in cycles (>=1)
MULT_LAT, 2, multiplier core latency in cycles (>=1)
DIV_TIMEOUT, 255, max WAIT cycles for divider result before abort (>=1)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_axis_op_tdata  in  2*DATA_WIDTH  {b, a}; a in low half
s_axis_op_tuser  in  OPP_WIDTH  opcode: 0 ADD, 1 MULT, 2 DIV quotient, 3 MOD remainder
s_axis_op_tvalid  in  1  operation valid
s_axis_op_tready  out  1  operation accepted when tvalid&tready
m_axis_res_tdata  out  DATA_WIDTH  result
m_axis_res_tuser  out  3  status {illegal_op, timeout, div_zero}
m_axis_res_tvalid  out  1  result valid
m_axis_res_tready  in  1  downstream ready
add_a, add_b  out  DATA_WIDTH  adder operands
add_sum  in  DATA_WIDTH  adder result
mult_a, mult_b  out  DATA_WIDTH  multiplier operands (product truncated to DATA_WIDTH)
mult_result  in  DATA_WIDTH  multiplier result
dividend_tdata  out  DATA_WIDTH  dividend (a)
dividend_tvalid  out  1  dividend valid
dividend_tready  in  1  divider accepts dividend
divisor_tdata  out  DATA_WIDTH/2  divisor (b low half)
divisor_tvalid  out  1  divisor valid
divisor_tready  in  1  divider accepts divisor
div_result_tvalid  in  1  divider result valid
div_result_tdata  in  DATA_WIDTH+DATA_WIDTH/2  {quotient[DATA_WIDTH], remainder[DATA_WIDTH/2]}
zero_error  in  1  divider divide-by-zero flag, qualified by div_result_tvalid
ops_done  out  32  completed-operation count (see Optional Feature)

Behaviour:
- Reset: state IDLE; all outputs 0; s_axis_op_tready 0 while aresetn low. Reset mid-operation aborts the operation: divider tvalids drop, no result is emitted, and the pending result is discarded.
- FSM states: IDLE, ISSUE, WAIT, OUTPUT.
- IDLE: s_axis_op_tready=1. On handshake, register a, b and opcode, then go to ISSUE. No other state accepts input.
- ISSUE, ADD/MULT: operand registers drive the core. Load timer with ADD_LAT or MULT_LAT. Go to WAIT.
- ISSUE, DIV/MOD with b[DATA_WIDTH/2-1:0]==0: do not issue to the divider. Result 0, div_zero=1. Go to OUTPUT.
- ISSUE, DIV/MOD otherwise: assert dividend_tvalid and divisor_tvalid. Each drops independently on its own ready. When both channels have handshaked, clear the timeout counter and go to WAIT. Time spent in ISSUE does not count toward timeout.
- ISSUE, illegal opcode: result 0, illegal_op=1. Go to OUTPUT.
- WAIT, ADD/MULT: timer decrements each cycle. At timer==1, capture add_sum or mult_result and go to OUTPUT. m_axis_res_tvalid rises exactly LAT+2 cycles after the input handshake cycle.
- WAIT, DIV/MOD: capture on div_result_tvalid. DIV returns the quotient. MOD returns the remainder zero-extended. If zero_error is set, result 0 and div_zero=1.
- WAIT, DIV/MOD timeout: if DIV_TIMEOUT cycles pass without div_result_tvalid, result 0 and timeout=1, then go to OUTPUT.
- Divider results outside WAIT are ignored.
- OUTPUT: m_axis_res_tvalid=1. tdata and tuser are held stable until m_axis_res_tready. On handshake, drop tvalid and go to IDLE. Handshake cycle plus one cycle later, IDLE is re-entered.
- Arithmetic: add and mult results are modulo 2^DATA_WIDTH, as delivered by the cores.

Optional Feature:
ALU_OP_COUNTERS_EN
- Defined: ops_done is a 32-bit counter, reset to 0. It increments on every m_axis_res handshake, including error results, and wraps from 0xFFFFFFFF to 0.
- Undefined: ops_done is tied to 0 and no counter logic is synthesised.

Test Plan:
- ADD a=5 b=7, m_tready held 0 for 4 cycles -> tvalid at handshake+3, tdata=12 held stable, tuser=0, then IDLE and tready=1.
- MULT a=0xFFFF_FFFF_FFFF_FFFF b=2 (MULT_LAT=2) -> tdata=0xFFFF_FFFF_FFFF_FFFE at handshake+4.
- DIV a=100 b=7 with divisor_tready delayed 3 cycles, divider returns {14,2} -> tdata=14. Same with MOD -> tdata=2.
- MOD b=0 -> no divider tvalid asserted, tdata=0, tuser=3'b001.
- DIV with divider silent (DIV_TIMEOUT=16) -> tuser=3'b010, tdata=0 after 16 WAIT cycles. A late div_result_tvalid in IDLE is ignored.
- aresetn low for 1 cycle during WAIT of MULT -> no result emitted, all outputs 0, next ADD 1+1 returns 2. With ALU_OP_COUNTERS_EN, ops_done=1 afterwards.
